// File: rtl/vproc_resp_pkg.sv
// Shared types and constants for the VProc bus responder and its RAM.
package vproc_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } resp_state_t;

    localparam logic [31:0] RESP_OOR_RDATA   = 32'h0;
    localparam int          RESP_BURST_WIDTH = 12;

    // True when any address bit above the RAM's word-address range is set.
    function automatic logic addrOutOfRange(input logic [31:0] addr, input int unsigned memAddrWidth);
        return (addr >> memAddrWidth) != 32'd0;
    endfunction

endpackage

// File: rtl/vproc_resp_mem.sv
// Single-port synchronous RAM with write enable and an enabled, resettable read register.
module vproc_resp_mem
    import vproc_resp_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      we_i,
    input  logic                      re_i,
    input  logic [MEM_ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]               wdata_i,
    output logic [31:0]               rdata_o
);

    logic [31:0] mem_q [2**MEM_ADDR_WIDTH];
    logic [31:0] rdata_q;

    // Array contents are deliberately never reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // The read register only updates on a read so the last word stays visible.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/vproc_bus_responder.sv
// Memory-backed VProc bus target with programmable wait states and sticky range checking.
// Optional burst support (Burst/BurstFirst/BurstLast ports) is enabled by defining VPROC_RESP_BURST_EN.
module vproc_bus_responder
    import vproc_resp_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int WAIT_WIDTH     = 4
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic [31:0]                 Addr,
    input  logic                        WE,
    input  logic                        RD,
    input  logic [31:0]                 DataOut,
    input  logic [WAIT_WIDTH-1:0]       WaitStates,
`ifdef VPROC_RESP_BURST_EN
    input  logic [RESP_BURST_WIDTH-1:0] Burst,
    input  logic                        BurstFirst,
    input  logic                        BurstLast,
`endif
    output logic [31:0]                 DataIn,
    output logic                        WRAck,
    output logic                        RDAck,
    output logic                        RangeErr,
    output logic [31:0]                 AccCount
);

    resp_state_t           state_q,    state_d;
    logic                  isWrite_q,  isWrite_d;
    logic [31:0]           addr_q,     addr_d;
    logic [WAIT_WIDTH-1:0] waitCnt_q,  waitCnt_d;
    logic                  wrAck_q,    wrAck_d;
    logic                  rdAck_q,    rdAck_d;
    logic                  rangeErr_q, rangeErr_d;
    logic [31:0]           accCount_q, accCount_d;
    logic                  rdZero_q,   rdZero_d;
`ifdef VPROC_RESP_BURST_EN
    logic [RESP_BURST_WIDTH-1:0] beatCnt_q, beatCnt_d;
    logic                        last_q,    last_d;
    logic [RESP_BURST_WIDTH-1:0] beatCur;
    logic                        lastCur;
`endif

    logic                  ackEdge;
    logic                  ackWrite;
    logic [31:0]           ackAddr;
    logic                  ackOor;
    logic [WAIT_WIDTH-1:0] effWait;
    logic                  memWe;
    logic                  memRe;
    logic [31:0]           memRdata;

    // A zero-wait request is accepted and acknowledged on the same edge, so the
    // ack-side signals come straight from the bus in IDLE and from the capture otherwise.
    always_comb begin
        state_d    = state_q;
        isWrite_d  = isWrite_q;
        addr_d     = addr_q;
        waitCnt_d  = waitCnt_q;
        wrAck_d    = 1'b0;
        rdAck_d    = 1'b0;
        rangeErr_d = rangeErr_q;
        accCount_d = accCount_q;
        rdZero_d   = rdZero_q;
        ackEdge    = 1'b0;
        ackWrite   = isWrite_q;
        ackAddr    = addr_q;
        ackOor     = 1'b0;
`ifdef VPROC_RESP_BURST_EN
        beatCnt_d  = beatCnt_q;
        last_d     = last_q;
        beatCur    = (state_q == IDLE && BurstFirst) ? Burst : beatCnt_q;
        lastCur    = (state_q == IDLE) ? BurstLast : last_q;
        effWait    = (BurstFirst || Burst == '0) ? WaitStates : '0;
`else
        effWait    = WaitStates;
`endif

        case (state_q)
            IDLE: begin
                if (WE || RD) begin
                    isWrite_d = WE;
                    addr_d    = Addr;
                    waitCnt_d = effWait;
`ifdef VPROC_RESP_BURST_EN
                    beatCnt_d = beatCur;
                    last_d    = BurstLast;
`endif
                    if (effWait == '0) begin
                        ackEdge  = 1'b1;
                        ackWrite = WE;
                        ackAddr  = Addr;
                        state_d  = ACK;
                    end else begin
                        state_d  = WAIT;
                    end
                end
            end
            WAIT: begin
                waitCnt_d = waitCnt_q - WAIT_WIDTH'(1);
                if (waitCnt_q == WAIT_WIDTH'(1)) begin
                    ackEdge = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (ackEdge) begin
            ackOor     = addrOutOfRange(ackAddr, MEM_ADDR_WIDTH);
            wrAck_d    = ackWrite;
            rdAck_d    = !ackWrite;
            accCount_d = accCount_q + 32'd1;
            if (ackOor) begin
                rangeErr_d = 1'b1;
            end
            if (!ackWrite) begin
                rdZero_d = ackOor;
            end
`ifdef VPROC_RESP_BURST_EN
            if (lastCur && beatCur != RESP_BURST_WIDTH'(1)) begin
                rangeErr_d = 1'b1;
            end
            if (beatCur != '0) begin
                beatCnt_d = beatCur - RESP_BURST_WIDTH'(1);
            end
`endif
        end
    end

    // RAM strobes are masked by Reset so an abandoned access never touches memory.
    assign memWe = ackEdge && ackWrite && !ackOor && !Reset;
    assign memRe = ackEdge && !ackWrite && !ackOor && !Reset;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            isWrite_q  <= 1'b0;
            addr_q     <= '0;
            waitCnt_q  <= '0;
            wrAck_q    <= 1'b0;
            rdAck_q    <= 1'b0;
            rangeErr_q <= 1'b0;
            accCount_q <= '0;
            rdZero_q   <= 1'b0;
`ifdef VPROC_RESP_BURST_EN
            beatCnt_q  <= '0;
            last_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            isWrite_q  <= isWrite_d;
            addr_q     <= addr_d;
            waitCnt_q  <= waitCnt_d;
            wrAck_q    <= wrAck_d;
            rdAck_q    <= rdAck_d;
            rangeErr_q <= rangeErr_d;
            accCount_q <= accCount_d;
            rdZero_q   <= rdZero_d;
`ifdef VPROC_RESP_BURST_EN
            beatCnt_q  <= beatCnt_d;
            last_q     <= last_d;
`endif
        end
    end

    vproc_resp_mem #(
        .MEM_ADDR_WIDTH(MEM_ADDR_WIDTH)
    ) u_mem (
        .clk_i   (Clk),
        .reset_i (Reset),
        .we_i    (memWe),
        .re_i    (memRe),
        .addr_i  (ackAddr[MEM_ADDR_WIDTH-1:0]),
        .wdata_i (DataOut),
        .rdata_o (memRdata)
    );

    // An out-of-range read masks the RAM register until the next in-range read.
    assign DataIn   = rdZero_q ? RESP_OOR_RDATA : memRdata;
    assign WRAck    = wrAck_q;
    assign RDAck    = rdAck_q;
    assign RangeErr = rangeErr_q;
    assign AccCount = accCount_q;

endmodule
